// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive paths:
//   OVERSAMPLE_DEF   default baud_pulse ticks per bit period (must be even)
//   WLS_5..WLS_8     word-length select encodings (5..8 data bits)
//   tx_state_t       transmitter frame states
//   tx_frame_cfg_t   line-control fields captured when a character is popped
//   word_mask()      mask of the data bits that belong to a character
//   last_bit()       index of the final data bit for a word length
//   calc_parity()    parity bit over the masked data bits
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Only the fields still needed after the pop; parity is resolved up
    // front, so eps/sticky_parity do not need to be held for the frame.
    typedef struct packed {
        logic [1:0] wls;
        logic       pen;
        logic       stb;
    } tx_frame_cfg_t;

    function automatic logic [7:0] word_mask(input logic [1:0] wls);
        case (wls)
            WLS_5:   return 8'h1F;
            WLS_6:   return 8'h3F;
            WLS_7:   return 8'h7F;
            WLS_8:   return 8'hFF;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [2:0] last_bit(input logic [1:0] wls);
        return 3'd4 + {1'b0, wls};
    endfunction

    // Even parity makes the total count of ones even (XOR of the data),
    // odd parity is its complement; stick parity forces the bit to ~eps.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic [1:0] wls,
                                         input logic       eps,
                                         input logic       sticky);
        logic odd_ones;
        odd_ones = ^(data & word_mask(wls));
        if (sticky)
            return ~eps;
        else if (eps)
            return odd_ones;
        else
            return ~odd_ones;
    endfunction

endpackage

// File: rtl/uart_tx_top_if.sv
// ---------------------------------------------------------------------------
// uart_tx_top_if
// Read side of the TX FIFO as seen by the transmitter.
//   fifo_empty  FIFO holds no character
//   din         head-of-FIFO data, show-ahead (valid while fifo_empty=0)
//   pop         one-clk read strobe; the head is consumed on that edge
// Modports: master = transmitter (issues pop), slave = FIFO.
// ---------------------------------------------------------------------------
interface uart_tx_top_if;

    logic       fifo_empty;
    logic [7:0] din;
    logic       pop;

    modport master (
        input  fifo_empty,
        input  din,
        output pop
    );

    modport slave (
        output fifo_empty,
        output din,
        input  pop
    );

endinterface

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Counts baud_pulse ticks against a programmable terminal count and flags
// the tick that completes the period. Shared by the transmitter and receiver.
//   clk, rst   clock, asynchronous active-high reset
//   clear      hold the count at zero (a tick in this cycle is not counted)
//   tick       one-clk oversample enable
//   term       ticks per period (e.g. 16, 24 or 32)
//   bit_done   high on the clk whose tick is the term-th of the period
// ---------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] term,
    output logic             bit_done
);

    logic [CNT_W-1:0] cnt;

    assign bit_done = tick && !clear && (cnt == term - CNT_W'(1));

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= bit_done ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_top.sv
// ---------------------------------------------------------------------------
// uart_tx_top
// UART transmit serializer. Pops one character from the TX FIFO and sends
// start bit, 5-8 data bits LSB-first, optional parity, and 1/1.5/2 stop bits,
// each bit lasting OVERSAMPLE baud_pulse ticks (stop may be 1.5x or 2x).
//   clk, rst        clock, asynchronous active-high reset
//   baud_pulse      one-clk oversample enable
//   pen, eps        parity enable, even parity select
//   sticky_parity   stick parity
//   stb             stop-bit select (1.5 stop for 5-bit words, else 2)
//   wls             word length select
//   set_break       force the line to spacing
//   fifo            TX FIFO read port (master modport)
//   sreg_empty      shifter idle
//   tx              serial line
// ---------------------------------------------------------------------------
module uart_tx_top
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF  // must be even
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_pulse,
    input  logic                 pen,
    input  logic                 eps,
    input  logic                 sticky_parity,
    input  logic                 stb,
    input  logic [1:0]           wls,
    input  logic                 set_break,
    uart_tx_top_if.master        fifo,
    output logic                 sreg_empty,
    output logic                 tx
);

    localparam int CNT_W = $clog2(2 * OVERSAMPLE + 1);

    localparam logic [CNT_W-1:0] TC_BIT    = CNT_W'(OVERSAMPLE);
    localparam logic [CNT_W-1:0] TC_STOP15 = CNT_W'(3 * OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] TC_STOP2  = CNT_W'(2 * OVERSAMPLE);

    tx_state_t        state;
    tx_frame_cfg_t    cfg;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic             par_bit;
    logic             tx_reg;

    logic [CNT_W-1:0] term;
    logic             bit_done;
    logic             timer_clear;

    // NOTE: give every always_comb output a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        term = TC_BIT;
        if (state == STOP && cfg.stb)
            term = (cfg.wls == WLS_5) ? TC_STOP15 : TC_STOP2;
    end

    // Holding the timer clear through IDLE also discards a tick that lands
    // on the pop edge, so START always gets a full OVERSAMPLE ticks.
    assign timer_clear = (state == IDLE);

    uart_bit_timer #(
        .CNT_W (CNT_W)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .tick     (baud_pulse),
        .term     (term),
        .bit_done (bit_done)
    );

    // pop is decoded from state so the FIFO sees it in the same cycle it
    // is consumed; gating with rst keeps it low while reset is asserted.
    assign fifo.pop = (state == IDLE) && !fifo.fifo_empty && !rst;

    // Break overrides the line without stalling the frame.
    assign tx = tx_reg & ~set_break;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cfg        <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            tx_reg     <= 1'b1;
            sreg_empty <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_reg     <= 1'b1;
                    sreg_empty <= 1'b1;
                    if (!fifo.fifo_empty) begin
                        // Snapshot everything the frame needs so later
                        // changes to the control inputs cannot disturb it.
                        shreg      <= fifo.din;
                        cfg        <= '{wls: wls, pen: pen, stb: stb};
                        par_bit    <= calc_parity(fifo.din, wls, eps, sticky_parity);
                        bit_cnt    <= '0;
                        tx_reg     <= 1'b0;
                        sreg_empty <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (bit_done) begin
                        tx_reg  <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == last_bit(cfg.wls)) begin
                            if (cfg.pen) begin
                                tx_reg <= par_bit;
                                state  <= PARITY;
                            end else begin
                                tx_reg <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            tx_reg  <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                PARITY: begin
                    if (bit_done) begin
                        tx_reg <= 1'b1;
                        state  <= STOP;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        sreg_empty <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: begin
                    tx_reg     <= 1'b1;
                    sreg_empty <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_top
// Self-checking bench for uart_tx_top. A line monitor decodes each frame
// (mid-bit samples, tick count, sreg_empty low time) and compares it with
// the expectation queued when the character was handed to the FIFO port.
// ---------------------------------------------------------------------------
module tb_uart_tx_top;

    localparam int OS = 16;  // ticks per bit
    localparam int BP = 6;   // clocks per baud_pulse

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_pulse;
    logic       pen, eps, sticky_parity, stb, set_break;
    logic [1:0] wls;
    logic       sreg_empty;
    logic       tx;

    uart_tx_top_if fifo_if ();

    uart_tx_top #(
        .OVERSAMPLE (OS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_pulse    (baud_pulse),
        .pen           (pen),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .stb           (stb),
        .wls           (wls),
        .set_break     (set_break),
        .fifo          (fifo_if),
        .sreg_empty    (sreg_empty),
        .tx            (tx)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pop_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: inputs change 1 time unit after the active edge; the
    // baud enable is generated here so the bench knows its phase.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        baud_pulse = ((cyc % BP) == 0);
    endtask

    // ---------------- scoreboard and line monitor -----------------------
    typedef struct {
        string       name;
        logic [15:0] bits;      // mid-bit samples, bit 0 = start bit
        int          nbits;     // samples that are compared
        int          ticks;     // baud ticks from pop edge to IDLE entry
        int          low;       // sreg_empty low clocks, -1 = not checked
        bit          chk_bits;
    } sb_item_t;

    sb_item_t sb[$];

    bit          mon_active = 1'b0;
    bit          pend_tick  = 1'b0;
    bit          last_tick;
    int          mon_ticks, mon_low, mon_nsamp;
    logic [15:0] mon_bits, mon_mask;
    sb_item_t    mon_it;

    initial begin
        forever begin
            @(negedge clk);
            last_tick = pend_tick;      // baud_pulse seen at the edge just passed
            pend_tick = baud_pulse;     // baud_pulse for the coming edge
            if (fifo_if.pop === 1'b1)
                pop_cnt++;
            if (rst !== 1'b0) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (sreg_empty === 1'b0) begin
                    mon_active = 1'b1;
                    mon_ticks  = 0;
                    mon_low    = 1;
                    mon_nsamp  = 0;
                    mon_bits   = '0;
                end
            end else begin
                if (last_tick) begin
                    mon_ticks++;
                    if ((mon_ticks % OS) == (OS / 2) && mon_nsamp < 16) begin
                        mon_bits[mon_nsamp] = tx;
                        mon_nsamp++;
                    end
                end
                if (sreg_empty === 1'b1) begin
                    mon_active = 1'b0;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_underflow: frame of %0d ticks, expected none", mon_ticks);
                    end else begin
                        mon_it   = sb.pop_front();
                        mon_mask = (16'h1 << mon_it.nbits) - 16'h1;
                        if (mon_it.chk_bits)
                            check({mon_it.name, " bits"}, 32'(mon_bits & mon_mask),
                                  32'(mon_it.bits & mon_mask));
                        check({mon_it.name, " ticks"}, 32'(mon_ticks), 32'(mon_it.ticks));
                        if (mon_it.low >= 0)
                            check({mon_it.name, " sreg_empty low clks"}, 32'(mon_low),
                                  32'(mon_it.low));
                    end
                end else begin
                    mon_low++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------------------------
    task automatic set_cfg(input logic [1:0] w, input logic p, input logic e,
                           input logic s, input logic sb_stb);
        wls = w; pen = p; eps = e; sticky_parity = s; stb = sb_stb;
    endtask

    task automatic push_exp(input string name, input logic [15:0] bits, input int nbits,
                            input int ticks, input int low, input bit chk_bits);
        sb_item_t it;
        it.name = name; it.bits = bits; it.nbits = nbits;
        it.ticks = ticks; it.low = low; it.chk_bits = chk_bits;
        sb.push_back(it);
    endtask

    // Present one character and let it be popped on an edge that also
    // carries a baud_pulse, so sreg_empty low time is exactly ticks*BP.
    task automatic send_aligned(input logic [7:0] d);
        while (baud_pulse !== 1'b1) step();
        fifo_if.din        = d;
        fifo_if.fifo_empty = 1'b0;
        step();
        fifo_if.fifo_empty = 1'b1;
        fifo_if.din        = 8'($urandom);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (sreg_empty !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check({name, " reaches idle"}, 32'(sreg_empty), 32'd1);
    endtask

    // ---------------- table of frames -----------------------------------
    typedef struct {
        string       name;
        logic [7:0]  din;
        logic [1:0]  wls;
        logic        pen, eps, sticky, stb;
        logic [15:0] bits;
        int          nbits;
        int          ticks;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string name, input logic [7:0] d, input logic [1:0] w,
                           input logic p, input logic e, input logic s, input logic sb_stb,
                           input logic [15:0] bits, input int nbits, input int ticks);
        vec_t v;
        v.name = name; v.din = d; v.wls = w; v.pen = p; v.eps = e; v.sticky = s;
        v.stb = sb_stb; v.bits = bits; v.nbits = nbits; v.ticks = ticks;
        vq.push_back(v);
    endtask

    int p0;

    initial begin
        rst = 1'b1;
        baud_pulse = 1'b0;
        set_break = 1'b0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        fifo_if.fifo_empty = 1'b1;
        fifo_if.din = 8'h00;

        //            name         din    wls   pen eps stk stb  bits      n   ticks
        add_vec("8O1 0x45",   8'h45, 2'b11, 1, 0, 0, 0, 16'h048A, 11, 176);
        add_vec("5E1.5 0xFF", 8'hFF, 2'b00, 1, 1, 0, 1, 16'h00FE,  8, 136);
        add_vec("7M1 0x00",   8'h00, 2'b10, 1, 0, 1, 0, 16'h0300, 10, 160);
        add_vec("7S1 0x00",   8'h00, 2'b10, 1, 1, 1, 0, 16'h0200, 10, 160);
        add_vec("6O1 0x3F",   8'h3F, 2'b01, 1, 0, 0, 0, 16'h01FE,  9, 144);
        add_vec("5N1.5 0x0A", 8'h0A, 2'b00, 0, 0, 0, 1, 16'h0054,  7, 120);
        add_vec("8E1 0x80",   8'h80, 2'b11, 1, 1, 0, 0, 16'h0700, 11, 176);
        add_vec("5O1 0xE0",   8'hE0, 2'b00, 1, 0, 0, 0, 16'h00C0,  8, 128);

        // Reset state, with a non-empty FIFO that must not be popped.
        repeat (3) step();
        fifo_if.fifo_empty = 1'b0;
        #1;
        check("reset tx", 32'(tx), 32'd1);
        check("reset pop", 32'(fifo_if.pop), 32'd0);
        check("reset sreg_empty", 32'(sreg_empty), 32'd1);
        fifo_if.fifo_empty = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        check("idle tx", 32'(tx), 32'd1);
        check("idle sreg_empty", 32'(sreg_empty), 32'd1);
        check("idle pop count", 32'(pop_cnt), 32'd0);

        // Table-driven frames.
        foreach (vq[i]) begin
            set_cfg(vq[i].wls, vq[i].pen, vq[i].eps, vq[i].sticky, vq[i].stb);
            push_exp(vq[i].name, vq[i].bits, vq[i].nbits, vq[i].ticks, vq[i].ticks * BP, 1'b1);
            p0 = pop_cnt;
            send_aligned(vq[i].din);
            wait_idle(vq[i].name, 3000);
            repeat (2) step();
            check({vq[i].name, " pops"}, 32'(pop_cnt - p0), 32'd1);
        end

        // Back-to-back 8N2: 0xA5 then 0x3C from a two-deep FIFO.
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp("b2b 0xA5", 16'h034A, 10, 176, 176 * BP, 1'b1);
        push_exp("b2b 0x3C", 16'h0278, 10, 176, -1, 1'b1);
        p0 = pop_cnt;
        while (baud_pulse !== 1'b1) step();
        fifo_if.din = 8'hA5;
        fifo_if.fifo_empty = 1'b0;
        step();
        fifo_if.din = 8'h3C;
        wait_idle("b2b first", 3000);
        check("b2b pop one clk after idle", 32'(fifo_if.pop), 32'd1);
        step();
        check("b2b second frame busy", 32'(sreg_empty), 32'd0);
        check("b2b pop only in idle", 32'(fifo_if.pop), 32'd0);
        check("b2b second start bit", 32'(tx), 32'd0);
        fifo_if.fifo_empty = 1'b1;
        wait_idle("b2b second", 3000);
        repeat (2) step();
        check("b2b pops", 32'(pop_cnt - p0), 32'd2);

        // Config changes mid-frame do not reach the frame in flight.
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("cfg hold 8N1 0x55", 16'h02AA, 10, 160, 160 * BP, 1'b1);
        send_aligned(8'h55);
        repeat (20) step();
        set_cfg(2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_idle("cfg hold", 3000);
        repeat (2) step();

        // Break mid-data: line forced low at once, frame still completes.
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("break 8N1 0xFF", 16'h0000, 0, 160, 160 * BP, 1'b0);
        send_aligned(8'hFF);
        repeat (300) step();
        check("pre-break data bit", 32'(tx), 32'd1);
        set_break = 1'b1;
        #1;
        check("break forces tx", 32'(tx), 32'd0);
        wait_idle("break", 3000);
        check("break holds idle line", 32'(tx), 32'd0);
        set_break = 1'b0;
        #1;
        check("break released", 32'(tx), 32'd1);
        repeat (2) step();

        // Reset during DATA aborts the frame; the next one starts cleanly.
        push_exp("post-reset 8N1 0x81", 16'h0302, 10, 160, -1, 1'b1);
        fifo_if.din = 8'h00;
        while (baud_pulse !== 1'b1) step();
        fifo_if.fifo_empty = 1'b0;
        step();
        fifo_if.fifo_empty = 1'b1;
        repeat (200) step();
        check("pre-reset data bit", 32'(tx), 32'd0);
        p0 = pop_cnt;
        rst = 1'b1;
        fifo_if.din = 8'h81;
        fifo_if.fifo_empty = 1'b0;
        #1;
        check("mid-frame reset tx", 32'(tx), 32'd1);
        check("mid-frame reset pop", 32'(fifo_if.pop), 32'd0);
        check("mid-frame reset sreg_empty", 32'(sreg_empty), 32'd1);
        repeat (2) step();
        rst = 1'b0;
        step();
        fifo_if.fifo_empty = 1'b1;
        check("post-reset start bit", 32'(tx), 32'd0);
        check("post-reset busy", 32'(sreg_empty), 32'd0);
        wait_idle("post-reset", 3000);
        repeat (2) step();
        check("post-reset pops", 32'(pop_cnt - p0), 32'd1);

        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_top.md
Name: uart_tx_top

Overview:
Transmit serializer of the 16550-compatible UART. It is the mirror stage of uart_rx_top and drives the serial line that the receiver samples. It pops one character from the TX FIFO, then shifts out the frame LSB-first, timed by the shared 16x baud_pulse enable:
- start bit
- 5-8 data bits
- optional parity bit
- 1, 1.5 or 2 stop bits

Line-control inputs carry the same meaning as on uart_rx_top.

Parameters:
- OVERSAMPLE, 16, baud_pulse ticks per bit period. Must be even so that 1.5 stop bits is integral.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- baud_pulse  in  1  one-clk-wide oversample enable
- pen  in  1  parity enable
- eps  in  1  even parity select
- sticky_parity  in  1  stick parity
- stb  in  1  stop-bit select
- wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- set_break  in  1  force line to spacing (0)
- fifo_empty  in  1  TX FIFO empty
- din  in  8  FIFO head data, show-ahead (valid whenever fifo_empty=0)
- pop  out  1  one-clk FIFO read strobe
- sreg_empty  out  1  shifter idle (TEMT contribution)
- tx  out  1  serial output

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; tick and bit counters = 0; shift register = 0.
  - tx_reg=1, pop=0, sreg_empty=1.
  - Asserting rst mid-frame aborts the frame immediately: line returns to 1 and the character is lost.
- Line output: tx = tx_reg & ~set_break, a combinational gate with no added latency. The state machine keeps running under break, so characters are still consumed.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE:
  - sreg_empty=1, tx_reg=1.
  - On any clk with fifo_empty=0: pop=1 for exactly that cycle.
  - On the same edge: latch din, wls, pen, eps, sticky_parity and stb; tx_reg<=0; tick counter cleared; state<=START.
  - Mid-frame changes to config inputs have no effect on the frame in flight.
  - baud_pulse is not required to start a frame.
- Bit timing:
  - Tick counter increments only on clocks where baud_pulse=1.
  - A bit ends on the edge where the OVERSAMPLE-th tick of that bit is counted; the next bit value appears on tx_reg at that same edge.
- START: lasts OVERSAMPLE ticks, then goes to DATA with tx_reg = data[0].
- DATA:
  - Shifts LSB-first; bit counter runs 0..N-1, where N = 5 + wls_latched.
  - Bits above N-1 are never transmitted.
  - After bit N-1: go to PARITY if pen=1, otherwise to STOP.
- PARITY bit (computed over the N masked data bits only):
  - sticky=0, eps=1: XOR of the bits (even parity).
  - sticky=0, eps=0: XNOR of the bits (odd parity).
  - sticky=1: ~eps.
- STOP:
  - tx_reg=1.
  - Length: OVERSAMPLE ticks if stb=0; 3*OVERSAMPLE/2 if stb=1 and wls=00; 2*OVERSAMPLE if stb=1 and wls!=00.
  - Then go to IDLE.
- sreg_empty: 0 from the pop edge until the edge entering IDLE.
- Back-to-back frames: one IDLE clk between the stop end and the next pop; the next start bit begins the following edge.
- baud_pulse on the pop cycle is not counted toward START.
- fifo_empty toggling during a frame is ignored; pop never asserts outside IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - WLS_5/6/7/8 constants
  - OVERSAMPLE default
  - a parity function (data, wls, eps, sticky), shared with uart_rx_top
- One sub-module, uart_bit_timer: counts baud_pulse ticks against a programmable terminal count (16/24/32) and emits bit_done. Reused by the receiver.

Test Plan:
- 8O1, baud_pulse every 6 clks, din=0x45, pen=1, eps=0, sticky=0, stb=0, wls=11:
  - line carries 0, 1,0,1,0,0,0,1,0, parity 0, stop 1.
  - each bit lasts 96 clks; sreg_empty low for 1056 clks; pop exactly once.
- 5E1.5, wls=00, din=0xFF, pen=1, eps=1, stb=1:
  - 5 data ones, parity 1, stop lasts 24 ticks.
  - upper 3 bits never appear.
- Sticky parity: wls=10, sticky=1, eps=0, din=0x00 -> parity bit 1; with eps=1 -> parity bit 0.
- Back-to-back: FIFO holds 0xA5 and 0x3C, 8N2:
  - second pop occurs exactly 1 clk after the first frame's IDLE entry.
  - stop of the first frame lasts 32 ticks.
- Break and config change:
  - set_break=1 mid-data -> tx=0 same cycle, frame still completes, sreg_empty returns to 1.
  - changing wls mid-frame does not alter the frame.
- Reset mid-frame: assert rst during DATA -> tx=1, pop=0, sreg_empty=1 asynchronously. After release with FIFO non-empty, the next frame starts cleanly.
